// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: data width, canonical NOP and the fetch FSM encoding.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {inst, pc} pairs; flush wins over push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_inst,
    input  logic [XLEN-1:0] push_pc,
    input  logic            pop,
    input  logic            flush,
    output logic [XLEN-1:0] head_inst,
    output logic [XLEN-1:0] head_pc,
    output logic [CW-1:0]   count,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request issue, in-flight/drop tracking and the decode-side buffer.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign trap on unaligned redirects.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   FS_BOOT   | first cycle after reset; no request, redirect deferred a cycle
//   FS_RUN    | issuing sequential requests while buffer/in-flight room exists
//   FS_HALTED | no new requests; in-flight responses still land in the buffer
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misalign,
`endif
    output logic            halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;
    logic            boot_redir_q;
    logic [XLEN-1:0] boot_redir_pc_q;
    logic [XLEN-1:0] tag_mem [FIFO_DEPTH];
    logic [AW-1:0]   tag_wr_q;
    logic [AW-1:0]   tag_rd_q;
    logic            misalign_q;

    logic            redir_go;
    logic [XLEN-1:0] redir_target;
    logic            redir_bad;
    logic            resp_eff;
    logic            accept;
    logic            room;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_inst;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;

    assign redir_go     = (state_q != FS_BOOT) && (redirect_valid || boot_redir_q);
    assign redir_target = redirect_valid ? redirect_pc : boot_redir_pc_q;
    assign resp_eff     = imem_resp_valid && (state_q != FS_BOOT);
    assign room         = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign accept       = imem_req_valid && imem_req_ready;
    assign push         = resp_eff && (drop_q == '0) && !redir_go;
    assign pop          = inst_valid && inst_ready && !redir_go;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_bad      = redir_go && (redir_target[1:0] != 2'b00);
    assign fetch_misalign = misalign_q;
`else
    assign redir_bad  = 1'b0;
    assign misalign_q = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN: begin
                imem_req_valid = !halt && !redir_go && room;
                if (halt && (inflight_q == '0)) state_d = FS_HALTED;
            end
            FS_HALTED: begin
                if (!halt && !misalign_q) state_d = FS_RUN;
            end
            default: state_d = FS_BOOT;
        endcase
        if (redir_bad) state_d = FS_HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= FS_BOOT;
            pc_q            <= RESET_VECTOR;
            inflight_q      <= '0;
            drop_q          <= '0;
            boot_redir_q    <= 1'b0;
            boot_redir_pc_q <= '0;
            tag_wr_q        <= '0;
            tag_rd_q        <= '0;
        end else begin
            state_q      <= state_d;
            boot_redir_q <= (state_q == FS_BOOT) && redirect_valid;
            if ((state_q == FS_BOOT) && redirect_valid) boot_redir_pc_q <= redirect_pc;
            inflight_q <= inflight_q + CW'(accept) - CW'(resp_eff);
            if (accept)   tag_wr_q <= tag_wr_q + 1'b1;
            if (resp_eff) tag_rd_q <= tag_rd_q + 1'b1;
            // Every request still out at a redirect is stale, except the one returning now.
            if (redir_go) begin
                pc_q   <= redir_target & ~32'h3;
                drop_q <= inflight_q - CW'(resp_eff);
            end else begin
                if (accept) pc_q <= pc_q + 32'd4;
                if (resp_eff && (drop_q != '0)) drop_q <= drop_q - 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)          misalign_q <= 1'b0;
        else if (redir_bad) misalign_q <= 1'b1;
    end
`endif

    // Tag queue runs in lock-step with memory order; dropped responses still retire a tag.
    always_ff @(posedge clk) begin
        if (accept && !reset) tag_mem[tag_wr_q] <= pc_q;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_inst (imem_resp_data),
        .push_pc   (tag_mem[tag_rd_q]),
        .pop       (pop),
        .flush     (redir_go),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_req_addr = pc_q;
    assign inst_valid    = !fifo_empty;
    assign inst          = fifo_empty ? INST_NOP : head_inst;
    assign inst_pc       = fifo_empty ? '0 : head_pc;
    assign halted        = (state_q == FS_HALTED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (inflight_q <= CW'(FIFO_DEPTH) && drop_q <= CW'(FIFO_DEPTH) && drop_q <= inflight_q)
                else $error("fetch counters out of range");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model of configurable latency.
// Build with FETCH_MISALIGN_CHECK_EN to exercise the misalign trap.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign  (fetch_misalign),
`endif
        .halted          (halted)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    int          cyc      = 0;
    int          lat      = 1;
    bit          last_acc = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] req_pc_model;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // One clock: sample handshakes before the edge, update the memory model after it.
    task automatic tick();
        bit          acc;
        logic [31:0] acc_addr;
        #1;
        acc      = imem_req_valid && imem_req_ready && !reset;
        acc_addr = imem_req_addr;
        if (acc) begin
            check_eq("req_addr", acc_addr, req_pc_model);
            req_pc_model += 32'd4;
        end
        if (!reset && !redirect_valid && inst_valid && inst_ready) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst", inst, mem_word(exp_pc));
            exp_pc += 32'd4;
            n_deliv++;
        end
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (acc) begin
                pend_addr.push_back(acc_addr);
                pend_due.push_back(cyc + lat - 1);
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        tick();
        tick();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, INST_NOP);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_addr", imem_req_addr, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        reset        = 1'b0;
        exp_pc       = 32'd0;
        req_pc_model = 32'd0;
        n_deliv      = 0;
        #1;
        check_eq("boot_no_req", 32'(imem_req_valid), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        exp_pc         = target & ~32'h3;
        req_pc_model   = target & ~32'h3;
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;

        // 1: cold start, sequential fetch with 1-cycle memory
        lat = 1;
        do_reset();
        tick();
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, 32'd0);
        repeat (12) tick();
        check_eq("t1_deliveries", 32'(n_deliv >= 3), 32'd1);

        // 2: decode stall fills the buffer and stops requests
        inst_ready = 1'b0;
        repeat (10) tick();
        check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
        check_eq("stall_inst_valid", 32'(inst_valid), 32'd1);
        check_eq("stall_pc", imem_req_addr, exp_pc + 32'd8);
        inst_ready = 1'b1;
        repeat (10) tick();

        // 3: redirect with two requests in flight
        lat   = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend_addr.size() + int'(imem_resp_valid) == 2) found = 1'b1;
            else tick();
        end
        check_eq("t3_two_inflight", 32'(found), 32'd1);
        do_redirect(32'h100);
        check_eq("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("t3_req_addr", imem_req_addr, 32'h100);
        repeat (12) tick();
        check_eq("t3_progress", 32'(exp_pc >= 32'h108), 32'd1);

        // 4: memory backpressure holds the request
        lat            = 1;
        imem_req_ready = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_valid", 32'(imem_req_valid), 32'd1);
            check_eq("hold_addr", imem_req_addr, req_pc_model);
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();

        // 5: halt with one request in flight
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (last_acc) found = 1'b1;
        end
        check_eq("t5_accept_seen", 32'(found), 32'd1);
        halt  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (halted) found = 1'b1;
        end
        check_eq("t5_halted", 32'(found), 32'd1);
        repeat (3) tick();
        check_eq("t5_no_req", 32'(imem_req_valid), 32'd0);
        check_eq("t5_all_delivered", exp_pc, req_pc_model);
        check_eq("t5_empty", 32'(inst_valid), 32'd0);
        halt = 1'b0;
        tick();
        check_eq("t5_resumed", 32'(halted), 32'd0);
        check_eq("t5_resume_valid", 32'(imem_req_valid), 32'd1);
        check_eq("t5_resume_addr", imem_req_addr, req_pc_model);

        // 5b: redirect while a push and a pop coincide
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_resp_valid && inst_valid && inst_ready) found = 1'b1;
        end
        check_eq("t5b_push_pop_seen", 32'(found), 32'd1);
        do_redirect(32'h200);
        check_eq("t5b_flushed", 32'(inst_valid), 32'd0);
        check_eq("t5b_nop", inst, INST_NOP);
        repeat (8) tick();
        check_eq("t5b_progress", 32'(exp_pc >= 32'h204), 32'd1);

        // 6: unaligned redirect target
`ifdef FETCH_MISALIGN_CHECK_EN
        do_redirect(32'h102);
        check_eq("t6_misalign", 32'(fetch_misalign), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        check_eq("t6_halted", 32'(halted), 32'd1);
        check_eq("t6_sticky", 32'(fetch_misalign), 32'd1);
`else
        do_redirect(32'h102);
        check_eq("t6_req_addr", imem_req_addr, 32'h100);
        repeat (8) tick();
        check_eq("t6_progress", 32'(exp_pc >= 32'h104), 32'd1);
`endif

        // reset in the middle of traffic abandons everything
        do_reset();
        repeat (8) tick();
        check_eq("post_reset_progress", 32'(n_deliv >= 2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
